// File: rtl/retire_lockstep_checker.sv
// retire_lockstep_checker
// Compares the in-order retirement streams of two RV32I cores at run time.
// Each core's retire records go into their own FIFO. Heads are popped in
// pairs and compared field by field under CMP_MASK. Mismatch, overflow and
// timeout errors are counted, and the first one is captured (sticky).
module retire_lockstep_checker #(
    parameter int         XLEN        = 32,
    parameter int         DEPTH       = 8,
    parameter logic [2:0] CMP_MASK    = 3'b111,
    parameter int         TIMEOUT     = 64,
    parameter int         STOP_ON_ERR = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     a_valid,
    input  logic [XLEN-1:0]          a_pc,
    input  logic [31:0]              a_instr,
    input  logic                     a_rd_we,
    input  logic [4:0]               a_rd_addr,
    input  logic [XLEN-1:0]          a_rd_data,
    input  logic                     b_valid,
    input  logic [XLEN-1:0]          b_pc,
    input  logic [31:0]              b_instr,
    input  logic                     b_rd_we,
    input  logic [4:0]               b_rd_addr,
    input  logic [XLEN-1:0]          b_rd_data,
    output logic [31:0]              cmp_count,
    output logic [15:0]              err_count,
    output logic                     err_valid,
    output logic [1:0]               err_code,
    output logic [2:0]               err_field,
    output logic [XLEN-1:0]          err_a_pc,
    output logic [XLEN-1:0]          err_b_pc,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   a_level,
    output logic [$clog2(DEPTH):0]   b_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    // One retirement record; 'we' holds the effective write enable (x0 writes
    // are stored as no write so the compare never has to look at rd_addr 0).
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            we;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } rec_t;

    // State encodings of the halt states equal the error code that caused them.
    typedef enum logic [1:0] {
        ST_RUN           = 2'd0,
        ST_HALT_MISMATCH = 2'd1,
        ST_HALT_OVERFLOW = 2'd2,
        ST_HALT_TIMEOUT  = 2'd3
    } state_t;

    state_t        state, state_next;
    rec_t          a_mem [DEPTH];
    rec_t          b_mem [DEPTH];
    logic [AW:0]   a_wr, a_rd, b_wr, b_rd;
    logic [TW-1:0] tcnt;

    rec_t        a_new, b_new, a_head, b_head;
    logic        run, a_empty, b_empty, a_full, b_full;
    logic        pop, a_push, b_push;
    logic [2:0]  diff;
    logic        mismatch, overflow, tmo_busy, tmo_hit;
    logic [1:0]  code;

    assign a_new = '{pc: a_pc, instr: a_instr, we: a_rd_we && (a_rd_addr != 5'd0),
                     addr: a_rd_addr, data: a_rd_data};
    assign b_new = '{pc: b_pc, instr: b_instr, we: b_rd_we && (b_rd_addr != 5'd0),
                     addr: b_rd_addr, data: b_rd_data};

    assign a_level = a_wr - a_rd;
    assign b_level = b_wr - b_rd;
    assign a_empty = (a_wr == a_rd);
    assign b_empty = (b_wr == b_rd);
    assign a_full  = (a_level == FULL_LVL);
    assign b_full  = (b_level == FULL_LVL);
    assign a_head  = a_mem[a_rd[AW-1:0]];
    assign b_head  = b_mem[b_rd[AW-1:0]];

    assign run     = (state == ST_RUN);
    assign halted  = !run;
    assign pop     = run && !a_empty && !b_empty;
    // A push to a full FIFO only fits when that FIFO is popped in the same cycle.
    assign a_push  = a_valid && (!a_full || pop);
    assign b_push  = b_valid && (!b_full || pop);

    // Field-by-field head comparison; rd_addr/rd_data only matter when both cores write.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        diff    = '0;
        diff[0] = CMP_MASK[0] && (a_head.pc != b_head.pc);
        diff[1] = CMP_MASK[1] && (a_head.instr != b_head.instr);
        diff[2] = CMP_MASK[2] &&
                  ((a_head.we != b_head.we) ||
                   (a_head.we && ((a_head.addr != b_head.addr) ||
                                  (a_head.data != b_head.data))));
    end

    assign mismatch = pop && (diff != 3'd0);
    assign overflow = run && !pop && ((a_valid && a_full) || (b_valid && b_full));
    // Counting only while exactly one side holds records; a pop needs both, so none occurs here.
    assign tmo_busy = (TIMEOUT != 0) && run && (a_empty != b_empty);
    assign tmo_hit  = tmo_busy && (tcnt == TW'(TIMEOUT - 1));

    // Error code of this cycle, highest priority first.
    always_comb begin
        code = 2'd0;
        if (mismatch)      code = 2'd1;
        else if (overflow) code = 2'd2;
        else if (tmo_hit)  code = 2'd3;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (!resetn) state <= ST_RUN;
        else         state <= state_next;
    end

    // Next state: the first error halts the checker when STOP_ON_ERR is set.
    always_comb begin
        state_next = state;
        if (run && (code != 2'd0) && (STOP_ON_ERR != 0))
            state_next = state_t'(code);
    end

    // FIFO pointers; a pop always advances both read pointers together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_wr <= '0;
            a_rd <= '0;
            b_wr <= '0;
            b_rd <= '0;
        end else begin
            if (a_push) a_wr <= a_wr + (AW + 1)'(1);
            if (b_push) b_wr <= b_wr + (AW + 1)'(1);
            if (pop) begin
                a_rd <= a_rd + (AW + 1)'(1);
                b_rd <= b_rd + (AW + 1)'(1);
            end
        end
    end

    // Record storage.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; the pointers alone say which entries are live.
        if (a_push) a_mem[a_wr[AW-1:0]] <= a_new;
        if (b_push) b_mem[b_wr[AW-1:0]] <= b_new;
    end

    // Counters, timeout counter and sticky first-error capture; all frozen outside RUN.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cmp_count <= '0;
            err_count <= '0;
            err_valid <= 1'b0;
            err_code  <= '0;
            err_field <= '0;
            err_a_pc  <= '0;
            err_b_pc  <= '0;
            tcnt      <= '0;
        end else if (run) begin
            if (pop && (diff == 3'd0)) cmp_count <= cmp_count + 32'd1;
            if (code != 2'd0) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (!err_valid) begin
                    err_valid <= 1'b1;
                    err_code  <= code;
                    err_field <= (code == 2'd1) ? diff : 3'd0;
                    err_a_pc  <= a_empty ? '0 : a_head.pc;
                    err_b_pc  <= b_empty ? '0 : b_head.pc;
                end
            end
            if (tmo_busy && !tmo_hit) tcnt <= tcnt + TW'(1);
            else                      tcnt <= '0;
        end
    end

endmodule

// File: tb/tb_retire_lockstep_checker.sv
// Testbench for retire_lockstep_checker: three instances with different
// parameter sets share one stimulus stream. A queue-based reference model per
// instance predicts every output after every clock edge.
module tb_retire_lockstep_checker;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } rec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [31:0] a_pc = '0, a_instr = '0, a_rd_data = '0;
    logic [31:0] b_pc = '0, b_instr = '0, b_rd_data = '0;
    logic        a_rd_we = 1'b0, b_rd_we = 1'b0;
    logic [4:0]  a_rd_addr = '0, b_rd_addr = '0;

    logic [31:0] cmp_count [3];
    logic [15:0] err_count [3];
    logic        err_valid [3];
    logic [1:0]  err_code  [3];
    logic [2:0]  err_field [3];
    logic [31:0] err_a_pc  [3];
    logic [31:0] err_b_pc  [3];
    logic        halted    [3];
    logic [3:0]  a_level   [3];
    logic [3:0]  b_level   [3];
    logic [3:0]  lv0a, lv0b;
    logic [2:0]  lv1a, lv1b;
    logic [1:0]  lv2a, lv2b;

    assign a_level[0] = lv0a;
    assign b_level[0] = lv0b;
    assign a_level[1] = {1'b0, lv1a};
    assign b_level[1] = {1'b0, lv1b};
    assign a_level[2] = {2'b00, lv2a};
    assign b_level[2] = {2'b00, lv2b};

    always #5 clk = ~clk;

    // Instance 0: all defaults.
    retire_lockstep_checker u0 (
        .clk(clk), .resetn(resetn),
        .a_valid(a_valid), .a_pc(a_pc), .a_instr(a_instr), .a_rd_we(a_rd_we),
        .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .b_valid(b_valid), .b_pc(b_pc), .b_instr(b_instr), .b_rd_we(b_rd_we),
        .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .cmp_count(cmp_count[0]), .err_count(err_count[0]), .err_valid(err_valid[0]),
        .err_code(err_code[0]), .err_field(err_field[0]), .err_a_pc(err_a_pc[0]),
        .err_b_pc(err_b_pc[0]), .halted(halted[0]), .a_level(lv0a), .b_level(lv0b)
    );

    // Instance 1: shallow, instruction word ignored, no timeout, keeps running.
    retire_lockstep_checker #(.DEPTH(4), .CMP_MASK(3'b101), .TIMEOUT(0), .STOP_ON_ERR(0)) u1 (
        .clk(clk), .resetn(resetn),
        .a_valid(a_valid), .a_pc(a_pc), .a_instr(a_instr), .a_rd_we(a_rd_we),
        .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .b_valid(b_valid), .b_pc(b_pc), .b_instr(b_instr), .b_rd_we(b_rd_we),
        .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .cmp_count(cmp_count[1]), .err_count(err_count[1]), .err_valid(err_valid[1]),
        .err_code(err_code[1]), .err_field(err_field[1]), .err_a_pc(err_a_pc[1]),
        .err_b_pc(err_b_pc[1]), .halted(halted[1]), .a_level(lv1a), .b_level(lv1b)
    );

    // Instance 2: minimum depth, short timeout, keeps running.
    retire_lockstep_checker #(.DEPTH(2), .CMP_MASK(3'b111), .TIMEOUT(5), .STOP_ON_ERR(0)) u2 (
        .clk(clk), .resetn(resetn),
        .a_valid(a_valid), .a_pc(a_pc), .a_instr(a_instr), .a_rd_we(a_rd_we),
        .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .b_valid(b_valid), .b_pc(b_pc), .b_instr(b_instr), .b_rd_we(b_rd_we),
        .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .cmp_count(cmp_count[2]), .err_count(err_count[2]), .err_valid(err_valid[2]),
        .err_code(err_code[2]), .err_field(err_field[2]), .err_a_pc(err_a_pc[2]),
        .err_b_pc(err_b_pc[2]), .halted(halted[2]), .a_level(lv2a), .b_level(lv2b)
    );

    function automatic int cfg_depth(int i);
        return (i == 0) ? 8 : (i == 1) ? 4 : 2;
    endfunction
    function automatic logic [2:0] cfg_mask(int i);
        return (i == 1) ? 3'b101 : 3'b111;
    endfunction
    function automatic int cfg_tmo(int i);
        return (i == 0) ? 64 : (i == 1) ? 0 : 5;
    endfunction
    function automatic bit cfg_stop(int i);
        return (i == 0);
    endfunction

    // Reference model state, one set per instance.
    rec_t        mq_a [3][$];
    rec_t        mq_b [3][$];
    int unsigned m_cmp  [3];
    int          m_errc [3];
    bit          m_ev   [3];
    bit          m_halt [3];
    logic [1:0]  m_code [3];
    logic [2:0]  m_field[3];
    logic [31:0] m_epa  [3];
    logic [31:0] m_epb  [3];
    int          m_idle [3];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Which enabled fields of two records disagree, from the comparison rules.
    function automatic logic [2:0] fields_differ(int i, rec_t a, rec_t b);
        logic [2:0] m = cfg_mask(i);
        bit wa = a.we && (a.addr != 0);
        bit wb = b.we && (b.addr != 0);
        logic [2:0] d = '0;
        if (m[0] && a.pc != b.pc)       d[0] = 1'b1;
        if (m[1] && a.instr != b.instr) d[1] = 1'b1;
        if (m[2]) begin
            if (wa != wb)                                        d[2] = 1'b1;
            else if (wa && (a.addr != b.addr || a.data != b.data)) d[2] = 1'b1;
        end
        return d;
    endfunction

    // Advance instance i's model by one clock edge given that edge's inputs.
    task automatic model_step(int i, bit rst_n, bit av, rec_t ar, bit bv, rec_t br);
        int   code = 0;
        logic [2:0] fld = '0;
        bit   ane, bne, pop;
        int   dep = cfg_depth(i);
        if (!rst_n) begin
            mq_a[i].delete();
            mq_b[i].delete();
            m_cmp[i] = 0; m_errc[i] = 0; m_ev[i] = 0; m_halt[i] = 0;
            m_code[i] = 0; m_field[i] = 0; m_epa[i] = 0; m_epb[i] = 0; m_idle[i] = 0;
            return;
        end
        ane = mq_a[i].size() > 0;
        bne = mq_b[i].size() > 0;
        pop = !m_halt[i] && ane && bne;
        if (pop) begin
            fld = fields_differ(i, mq_a[i][0], mq_b[i][0]);
            if (fld != 0) code = 1;
            else          m_cmp[i] = m_cmp[i] + 1;
        end
        if (!m_halt[i] && !pop && code == 0 &&
            ((av && mq_a[i].size() == dep) || (bv && mq_b[i].size() == dep)))
            code = 2;
        if (!m_halt[i]) begin
            if (cfg_tmo(i) != 0 && (ane != bne)) begin
                m_idle[i]++;
                if (m_idle[i] == cfg_tmo(i)) begin
                    m_idle[i] = 0;
                    if (code == 0) code = 3;
                end
            end else begin
                m_idle[i] = 0;
            end
        end
        if (code != 0) begin
            if (m_errc[i] < 65535) m_errc[i]++;
            if (!m_ev[i]) begin
                m_ev[i]    = 1;
                m_code[i]  = 2'(code);
                m_field[i] = (code == 1) ? fld : 3'd0;
                m_epa[i]   = ane ? mq_a[i][0].pc : 32'd0;
                m_epb[i]   = bne ? mq_b[i][0].pc : 32'd0;
                if (cfg_stop(i)) m_halt[i] = 1;
            end
        end
        if (pop) begin
            void'(mq_a[i].pop_front());
            void'(mq_b[i].pop_front());
        end
        if (av && mq_a[i].size() < dep) mq_a[i].push_back(ar);
        if (bv && mq_b[i].size() < dep) mq_b[i].push_back(br);
    endtask

    task automatic check_inst(int i);
        check($sformatf("u%0d.cmp_count", i), 64'(cmp_count[i]), 64'(m_cmp[i]));
        check($sformatf("u%0d.err_count", i), 64'(err_count[i]), 64'(m_errc[i]));
        check($sformatf("u%0d.err_valid", i), 64'(err_valid[i]), 64'(m_ev[i]));
        check($sformatf("u%0d.err_code", i),  64'(err_code[i]),  64'(m_code[i]));
        check($sformatf("u%0d.err_field", i), 64'(err_field[i]), 64'(m_field[i]));
        check($sformatf("u%0d.err_a_pc", i),  64'(err_a_pc[i]),  64'(m_epa[i]));
        check($sformatf("u%0d.err_b_pc", i),  64'(err_b_pc[i]),  64'(m_epb[i]));
        check($sformatf("u%0d.halted", i),    64'(halted[i]),    64'(m_halt[i]));
        check($sformatf("u%0d.a_level", i),   64'(a_level[i]),   64'(mq_a[i].size()));
        check($sformatf("u%0d.b_level", i),   64'(b_level[i]),   64'(mq_b[i].size()));
    endtask

    // Drive one cycle of inputs, let the edge happen, update models, compare.
    task automatic step(bit rst_n, bit av, rec_t ar, bit bv, rec_t br);
        resetn    = rst_n;
        a_valid   = av; a_pc = ar.pc; a_instr = ar.instr; a_rd_we = ar.we;
        a_rd_addr = ar.addr; a_rd_data = ar.data;
        b_valid   = bv; b_pc = br.pc; b_instr = br.instr; b_rd_we = br.we;
        b_rd_addr = br.addr; b_rd_data = br.data;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, rst_n, av, ar, bv, br);
        #1;
        for (int i = 0; i < 3; i++) check_inst(i);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    function automatic rec_t rand_rec(int idx);
        rec_t r;
        r.pc    = 32'h1000 + 32'(idx) * 4;
        r.instr = $urandom;
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        r.data  = $urandom;
        return r;
    endfunction

    function automatic rec_t corrupt(rec_t r);
        rec_t c = r;
        case ($urandom_range(0, 3))
            0:       c.pc    = r.pc ^ 32'h4;
            1:       c.instr = r.instr ^ (32'h1 << $urandom_range(0, 31));
            2:       c.data  = r.data ^ 32'h1;
            default: c.we    = ~r.we;
        endcase
        return c;
    endfunction

    // Random traffic: both cores retire the same program at independent rates;
    // B occasionally retires a corrupted copy and the run is occasionally reset.
    task automatic run_random(int cycles, int pa, int pb, int pcor, int prst);
        rec_t gen[$];
        int   na = 0, nb = 0;
        for (int c = 0; c < cycles; c++) begin
            bit   av, bv;
            rec_t ar = '0, br = '0;
            if ($urandom_range(0, 999) < prst) begin
                step(1'b0, 1'b0, '0, 1'b0, '0);
                gen.delete();
                na = 0;
                nb = 0;
                continue;
            end
            av = $urandom_range(0, 99) < pa;
            bv = $urandom_range(0, 99) < pb;
            if (av) begin
                while (gen.size() <= na) gen.push_back(rand_rec(gen.size()));
                ar = gen[na];
                na++;
            end
            if (bv) begin
                while (gen.size() <= nb) gen.push_back(rand_rec(gen.size()));
                br = gen[nb];
                nb++;
                if ($urandom_range(0, 99) < pcor) br = corrupt(br);
            end
            step(1'b1, av, ar, bv, br);
        end
    endtask

    rec_t prog [6];
    rec_t progb[6];

    // Lockstep run: A retires prog at cycles 0..5, B retires progb 3 cycles later.
    task automatic run_loop();
        for (int c = 0; c < 9; c++) begin
            bit   av = (c < 6);
            bit   bv = (c >= 3);
            rec_t ar = av ? prog[c] : '0;
            rec_t br = bv ? progb[c - 3] : '0;
            step(1'b1, av, ar, bv, br);
        end
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rec_t r, s;
        prog[0] = '{pc: 32'h00, instr: 32'h04000093, we: 1'b1, addr: 5'd1, data: 32'd64};
        prog[1] = '{pc: 32'h04, instr: 32'h00112023, we: 1'b0, addr: 5'd0, data: 32'd0};
        prog[2] = '{pc: 32'h08, instr: 32'h00012183, we: 1'b1, addr: 5'd3, data: 32'd64};
        prog[3] = '{pc: 32'h0C, instr: 32'h00110113, we: 1'b1, addr: 5'd2, data: 32'd1};
        prog[4] = '{pc: 32'h10, instr: 32'h00312223, we: 1'b0, addr: 5'd0, data: 32'd0};
        prog[5] = '{pc: 32'h14, instr: 32'hFEDFF06F, we: 1'b1, addr: 5'd0, data: 32'h18};

        // Reset state.
        do_reset();
        check("reset.u0.cmp_count", 64'(cmp_count[0]), 64'd0);
        check("reset.u0.err_valid", 64'(err_valid[0]), 64'd0);

        // Lockstep: identical streams, B delayed by 3 cycles.
        progb = prog;
        run_loop();
        check("lockstep.u0.cmp_count", 64'(cmp_count[0]), 64'd6);
        check("lockstep.u0.err_valid", 64'(err_valid[0]), 64'd0);
        check("lockstep.u1.cmp_count", 64'(cmp_count[1]), 64'd6);

        // Data mismatch on the 4th pair (addi x2 at PC 0x0C).
        do_reset();
        progb = prog;
        progb[3].data = 32'h2;
        run_loop();
        check("datamis.u0.err_valid", 64'(err_valid[0]), 64'd1);
        check("datamis.u0.err_code",  64'(err_code[0]),  64'd1);
        check("datamis.u0.err_field", 64'(err_field[0]), 64'b100);
        check("datamis.u0.err_a_pc",  64'(err_a_pc[0]),  64'h0C);
        check("datamis.u0.err_b_pc",  64'(err_b_pc[0]),  64'h0C);
        check("datamis.u0.halted",    64'(halted[0]),    64'd1);
        check("datamis.u0.cmp_count", 64'(cmp_count[0]), 64'd3);

        // x0 write vs no write, differing instruction words: only u1 ignores instr.
        do_reset();
        r = '{pc: 32'h40, instr: 32'h00500013, we: 1'b1, addr: 5'd0, data: 32'd5};
        s = '{pc: 32'h40, instr: 32'h00000013, we: 1'b0, addr: 5'd0, data: 32'd0};
        step(1'b1, 1'b1, r, 1'b1, s);
        idle(1);
        check("x0mask.u1.cmp_count", 64'(cmp_count[1]), 64'd1);
        check("x0mask.u1.err_valid", 64'(err_valid[1]), 64'd0);
        check("x0mask.u0.err_code",  64'(err_code[0]),  64'd1);
        check("x0mask.u0.err_field", 64'(err_field[0]), 64'b010);

        // Overflow: A pushes 9 records while B stays idle.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            r = rand_rec(k);
            r.pc = 32'h100 + 32'(k) * 4;
            step(1'b1, 1'b1, r, 1'b0, '0);
        end
        check("ovf.u0.a_level",  64'(a_level[0]),  64'd8);
        check("ovf.u0.err_code", 64'(err_code[0]), 64'd2);
        check("ovf.u0.err_a_pc", 64'(err_a_pc[0]), 64'h100);
        check("ovf.u0.err_b_pc", 64'(err_b_pc[0]), 64'd0);

        // Timeout: one A record, B silent for 1000 cycles.
        do_reset();
        r = rand_rec(0);
        step(1'b1, 1'b1, r, 1'b0, '0);
        for (int j = 1; j <= 1000; j++) begin
            idle(1);
            if (j == 63) check("tmo.u0.before", 64'(err_valid[0]), 64'd0);
            if (j == 64) check("tmo.u0.err_code", 64'(err_code[0]), 64'd3);
        end
        check("tmo.u1.err_valid", 64'(err_valid[1]), 64'd0);
        check("tmo.u2.err_count", 64'(err_count[2]), 64'd200);

        // Keep-running mode: 10 pairs, PC corrupted on pairs 2, 5 and 8.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            r = rand_rec(k);
            r.pc = 32'h200 + 32'(k) * 4;
            s = r;
            if (k == 2 || k == 5 || k == 8) s.pc = r.pc ^ 32'h4;
            step(1'b1, 1'b1, r, 1'b1, s);
        end
        idle(1);
        check("nostop.u2.err_count", 64'(err_count[2]), 64'd3);
        check("nostop.u2.cmp_count", 64'(cmp_count[2]), 64'd7);
        check("nostop.u2.err_field", 64'(err_field[2]), 64'b001);
        check("nostop.u2.err_a_pc",  64'(err_a_pc[2]),  64'h208);
        check("nostop.u2.err_b_pc",  64'(err_b_pc[2]),  64'h20C);
        check("nostop.u2.halted",    64'(halted[2]),    64'd0);

        // Reset in the middle of a stream discards everything.
        for (int k = 0; k < 3; k++) begin
            r = rand_rec(k);
            step(1'b1, 1'b1, r, 1'b0, '0);
        end
        step(1'b0, 1'b0, '0, 1'b0, '0);
        check("midrst.u2.cmp_count", 64'(cmp_count[2]), 64'd0);
        check("midrst.u2.err_count", 64'(err_count[2]), 64'd0);
        check("midrst.u1.a_level",   64'(a_level[1]),   64'd0);
        idle(2);

        // Randomized traffic.
        do_reset();
        run_random(600, 50, 50, 5, 5);
        do_reset();
        run_random(400, 80, 30, 0, 10);
        do_reset();
        run_random(400, 10, 10, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
